// File: rtl/buffer2axis.sv
// Streams one WIDTH*HEIGHT binary grid as AXI-Stream pixels, one pixel per beat.
// Each bit is mapped to alive/dead colour, and TLAST marks pixel N-1.
module buffer2axis #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DWIDTH-1:0]         alive_color,
  input  logic [DWIDTH-1:0]         dead_color,
  input  logic [WIDTH*HEIGHT-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic                      frame_done
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [CW-1:0]       counter;
  logic [N-1:0]        grid_q;
  logic [DWIDTH-1:0]   alive_q;
  logic [DWIDTH-1:0]   dead_q;
  logic                beat_last;

  assign beat_last = (counter == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      counter    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            counter <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (beat_last) begin
              counter    <= '0;
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              counter <= counter + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame payload is deliberately left out of reset; it only loads on acceptance.
  always_ff @(posedge clk) begin
    if (rstn && state == IDLE && in_valid) begin
      grid_q  <= in_data;
      alive_q <= alive_color;
      dead_q  <= dead_color;
    end
  end

  assign in_ready      = (state == IDLE);
  assign M_AXIS_TVALID = (state == SEND);
  assign M_AXIS_TLAST  = (state == SEND) && beat_last;
  assign M_AXIS_TDATA  = grid_q[counter] ? alive_q : dead_q;

endmodule

// File: tb/tb_buffer2axis.sv
// Self-checking bench for buffer2axis (4x4 grid): frame-level queue model plus
// directed literal expectations on captured beats.
module tb_buffer2axis;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] alive_color, dead_color;
  logic [N-1:0]  in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast, frame_done;

  always #5 clk = ~clk;

  buffer2axis #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rstn(rstn),
    .alive_color(alive_color), .dead_color(dead_color),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  // Model: an accepted grid becomes a queue of N expected beats; one pops per ready cycle.
  beat_t exp_q[$];
  beat_t mb;
  bit    busy = 0, exp_done = 0, chk_en = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      busy = 0; exp_done = 0; chk_en = 1;
    end else if (busy) begin
      exp_done = 0;
      if (tready) begin
        mb = exp_q.pop_front();
        if (mb.last) begin busy = 0; exp_done = 1; end
      end
    end else begin
      exp_done = 0;
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          mb.data = in_data[i] ? alive_color : dead_color;
          mb.last = (i == N - 1);
          exp_q.push_back(mb);
        end
        busy = 1;
      end
    end
  end

  // Compare process and beat capture, away from the active edge.
  beat_t cap[$];
  beat_t cb;
  int    done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", tvalid, busy);
      check("in_ready", in_ready, !busy);
      check("frame_done", frame_done, exp_done);
      if (busy) begin
        check("tdata", tdata, exp_q[0].data);
        check("tlast", tlast, exp_q[0].last);
      end
      if (tvalid && tready) begin
        cb.data = tdata; cb.last = tlast;
        cap.push_back(cb);
      end
      if (frame_done) done_cnt++;
    end
  end

  // TREADY driver: fixed level or 50% random, updated after the active edge.
  bit ready_rand = 0;
  bit ready_lvl  = 1;
  always @(posedge clk) begin
    #2;
    tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  task automatic wait_beats(input int n, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (cap.size() >= n) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("beat_timeout", 64'(cap.size()), 64'(n));
  endtask

  task automatic send_frame(input logic [N-1:0] d);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [DW-1:0] ref_beats [N];
  logic [N-1:0]  grid, rebuilt;
  int            n_alive, n_last;

  initial begin
    alive_color = 32'h00FF_FFFF; dead_color = 32'h0;
    in_data = 16'hBEEF; in_valid = 1'b1; tready = 1'b1;

    // 1: reset held 3 cycles with in_valid asserted
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1; in_valid = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_tvalid", tvalid, 1'b0);
    check("reset_tlast", tlast, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    @(posedge clk); #1;

    // 2: A5A5 with TREADY=1
    cap.delete(); done_cnt = 0;
    send_frame(16'hA5A5);
    wait_beats(N, 100);
    @(posedge clk); #1;
    check("t2_beat0", cap[0].data, 32'h00FF_FFFF);
    check("t2_beat1", cap[1].data, 32'h0);
    check("t2_beat2", cap[2].data, 32'h00FF_FFFF);
    check("t2_beat5", cap[5].data, 32'h00FF_FFFF);
    check("t2_beat7", cap[7].data, 32'h00FF_FFFF);
    check("t2_beat14", cap[14].data, 32'h0);
    check("t2_beat15", cap[15].data, 32'h00FF_FFFF);
    n_alive = 0; n_last = 0;
    for (int i = 0; i < N; i++) begin
      ref_beats[i] = cap[i].data;
      if (cap[i].data == 32'h00FF_FFFF) n_alive++;
      if (cap[i].last) n_last++;
    end
    check("t2_alive_count", 64'(n_alive), 64'd8);
    check("t2_last_count", 64'(n_last), 64'd1);
    check("t2_last_on_15", cap[15].last, 1'b1);
    check("t2_done_pulses", 64'(done_cnt), 64'd1);

    // 3: same grid, random backpressure
    ready_rand = 1;
    cap.delete();
    send_frame(16'hA5A5);
    wait_beats(N, 400);
    for (int i = 0; i < N; i++) check("t3_same_seq", cap[i].data, ref_beats[i]);
    ready_rand = 0; ready_lvl = 1;
    @(posedge clk); #1;

    // 4: input changes during SEND are deferred to the next frame
    cap.delete();
    send_frame(16'hA5A5);
    in_data = 16'hFFFF; in_valid = 1'b1; alive_color = 32'h123;
    wait_beats(N, 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_beats(2 * N, 100);
    for (int i = 0; i < N; i++) check("t4_first_frame", cap[i].data, ref_beats[i]);
    for (int i = N; i < 2 * N; i++) check("t4_second_frame", cap[i].data, 32'h123);
    alive_color = 32'h00FF_FFFF;
    @(posedge clk); #1;

    // 5: reset after beat 6 aborts, next frame restarts at pixel 0
    cap.delete();
    send_frame(16'hA5A5);
    wait_beats(7, 100);
    rstn = 1'b0; ready_lvl = 0;
    @(posedge clk); #1;
    rstn = 1'b1; ready_lvl = 1;
    check("t5_tvalid_after_abort", tvalid, 1'b0);
    check("t5_aborted_beats", 64'(cap.size()), 64'd7);
    n_last = 0;
    foreach (cap[i]) if (cap[i].last) n_last++;
    check("t5_no_tlast", 64'(n_last), 64'd0);
    cap.delete();
    send_frame(16'h0001);
    wait_beats(N, 100);
    check("t5_beat0", cap[0].data, 32'h00FF_FFFF);
    n_alive = 0;
    for (int i = 1; i < N; i++) if (cap[i].data != 32'h0) n_alive++;
    check("t5_rest_dead", 64'(n_alive), 64'd0);
    check("t5_last", cap[15].last, 1'b1);
    @(posedge clk); #1;

    // alive == dead: every beat carries the shared colour
    alive_color = 32'hABC; dead_color = 32'hABC;
    cap.delete();
    send_frame(16'h5A0F);
    wait_beats(N, 100);
    for (int i = 0; i < N; i++) check("same_color", cap[i].data, 32'hABC);
    alive_color = 32'h00FF_FFFF; dead_color = 32'h0;
    @(posedge clk); #1;

    // 6: random grids with random backpressure, rebuilt from the stream
    ready_rand = 1;
    for (int f = 0; f < 20; f++) begin
      grid = 16'($urandom);
      cap.delete();
      send_frame(grid);
      wait_beats(N, 400);
      rebuilt = '0;
      for (int i = 0; i < N; i++) rebuilt[i] = (cap[i].data == 32'h00FF_FFFF);
      check("t6_loopback", rebuilt, grid);
    end
    ready_rand = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
